rps_match_scheduler: RTL and testbench

Sequences one two-player match: menu/settings navigation, per-turn move collection with a speed-scaled timeout, round resolution, score keeping and best-of-N match end. Sits between the debounced/one-pulsed buttons plus player move inputs and the display/audio blocks. Replaces the ad-hoc game state logic with one registered controller.

---
 rtl/game_pkg.sv | 32 +++
 rtl/turn_timer.sv | 49 ++++
 rtl/rps_match_scheduler.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_rps_match_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the rock-paper-scissors match scheduler.
//   - state_e  : controller state codes (also driven out on the state port)
//   - winner_e : match winner codes
//   - move_t   : 2-bit player move encoding (00 none, 01 rock, 10 paper, 11 scissors)
//   - turn_load: turn length for a given speed setting (base ticks >> speed)
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b001,
    ST_SETTING   = 3'b100,
    ST_COLLECT   = 3'b010,
    ST_RESOLVE   = 3'b101,
    ST_ROUND_END = 3'b110,
    ST_MATCH_END = 3'b011
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  // Rounds only compare moves for equality, so the encoding is opaque here.
  typedef logic [1:0] move_t;

  // Each speed step halves the time a player has to commit a move.
  function automatic logic [31:0] turn_load(input logic [31:0] base,
                                            input logic [1:0]  speed);
    return base >> speed;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// turn_timer: loadable down-counter advanced by the game time-base.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : force count to 0 (highest priority)
//   load       : load load_val
//   load_val   : TW-bit reload value
//   tick       : one-cycle time-base enable; decrements a non-zero count
//   count      : current count
//   expire     : combinational, high on the tick that takes count from 1 to 0
// Used both for the per-turn move deadline and for the round-result hold.
module turn_timer
  import game_pkg::*;
#(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic [TW-1:0] count,
  output logic          expire
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = tick && (count_q == TW'(1));

endmodule

// File: rtl/rps_match_scheduler.sv
// rps_match_scheduler: registered controller for one two-player
// rock-paper-scissors match (menu/settings, move collection with a
// speed-scaled deadline, round resolution, scoring, best-of-N end).
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start_pulse         : start / confirm (one cycle)
//   set_pulse           : settings / abort (one cycle)
//   tick                : game time-base enable (one cycle)
//   p1_move, p1_valid   : player 1 move and strobe
//   p2_move, p2_valid   : player 2 move and strobe (ignored in PVE)
//   cpu_move            : generated move, taken for player 2 in PVE
//   cfg_pve, cfg_speed  : configuration, latched on match start
//   state               : current state code (game_pkg::state_e)
//   turn                : attacker, 0 = p1, 1 = p2
//   timer               : ticks remaining in the current turn
//   p1_score, p2_score  : round wins
//   round_done          : high for the single RESOLVE cycle
//   winner              : 00 none, 01 p1, 10 p2
//
// Build option GAME_TIMEOUT_EN: when defined, each turn has a deadline of
// TURN_TICKS >> speed ticks and a missing move is resolved as a forfeit.
// When undefined the timer reads 0 and a turn waits for both moves.
module rps_match_scheduler
  import game_pkg::*;
#(
  parameter int TURN_TICKS    = 8,
  parameter int TW            = 4,
  parameter int WINS_TO_MATCH = 3,
  parameter int ROUND_HOLD    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_pulse,
  input  logic          set_pulse,
  input  logic          tick,
  input  logic [1:0]    p1_move,
  input  logic          p1_valid,
  input  logic [1:0]    p2_move,
  input  logic          p2_valid,
  input  logic [1:0]    cpu_move,
  input  logic          cfg_pve,
  input  logic [1:0]    cfg_speed,
  output logic [2:0]    state,
  output logic          turn,
  output logic [TW-1:0] timer,
  output logic [1:0]    p1_score,
  output logic [1:0]    p2_score,
  output logic          round_done,
  output logic [1:0]    winner
);

  localparam logic [1:0] WIN_SC = 2'(WINS_TO_MATCH);

  state_e  state_q, state_d;
  logic    turn_q, turn_d;
  logic [1:0] p1_score_q, p1_score_d;
  logic [1:0] p2_score_q, p2_score_d;
  logic    round_done_q, round_done_d;
  winner_e winner_q, winner_d;
  logic    pve_q, pve_d;
  logic [1:0] speed_q, speed_d;
  logic    p1_cap_q, p1_cap_d;
  logic    p2_cap_q, p2_cap_d;
  move_t   p1_mv_q, p1_mv_d;
  move_t   p2_mv_q, p2_mv_d;

  logic          tmr_clear, tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic [TW-1:0] tmr_count;
  logic          tmr_expire;

  logic p1_take, p2_take;
  logic p1_inc, p2_inc, turn_toggle;

`ifdef GAME_TIMEOUT_EN
  function automatic logic [TW-1:0] turn_len(input logic [1:0] spd);
    return TW'(turn_load(32'(TURN_TICKS), spd));
  endfunction
`endif

  turn_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tick),
    .count    (tmr_count),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    turn_d       = turn_q;
    p1_score_d   = p1_score_q;
    p2_score_d   = p2_score_q;
    winner_d     = winner_q;
    pve_d        = pve_q;
    speed_d      = speed_q;
    p1_cap_d     = p1_cap_q;
    p2_cap_d     = p2_cap_q;
    p1_mv_d      = p1_mv_q;
    p2_mv_d      = p2_mv_q;
    tmr_clear    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    p1_take      = 1'b0;
    p2_take      = 1'b0;
    p1_inc       = 1'b0;
    p2_inc       = 1'b0;
    turn_toggle  = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        // start wins over set when both arrive together
        if (start_pulse) begin
          state_d    = ST_COLLECT;
          pve_d      = cfg_pve;
          speed_d    = cfg_speed;
          p1_score_d = '0;
          p2_score_d = '0;
          winner_d   = WIN_NONE;
          turn_d     = 1'b0;
          p1_cap_d   = 1'b0;
          p2_cap_d   = 1'b0;
`ifdef GAME_TIMEOUT_EN
          // speed is being latched this cycle, so load from the live input
          tmr_load     = 1'b1;
          tmr_load_val = turn_len(cfg_speed);
`else
          tmr_clear    = 1'b1;
`endif
        end else if (set_pulse) begin
          state_d = ST_SETTING;
        end
      end

      ST_SETTING: begin
        if (set_pulse) begin
          state_d = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        if (set_pulse) begin
          state_d    = ST_IDLE;
          p1_score_d = '0;
          p2_score_d = '0;
          winner_d   = WIN_NONE;
          tmr_clear  = 1'b1;
        end else begin
          // first strobe per player wins; in PVE the CPU commits with p1
          p1_take = p1_valid && !p1_cap_q;
          p2_take = pve_q ? p1_take : (p2_valid && !p2_cap_q);
          if (p1_take) begin
            p1_cap_d = 1'b1;
            p1_mv_d  = p1_move;
          end
          if (p2_take) begin
            p2_cap_d = 1'b1;
            p2_mv_d  = pve_q ? cpu_move : p2_move;
          end
`ifdef GAME_TIMEOUT_EN
          // a strobe on the expiring tick is already folded into *_cap_d
          if ((p1_cap_d && p2_cap_d) || tmr_expire) begin
            state_d = ST_RESOLVE;
          end
`else
          if (p1_cap_d && p2_cap_d) begin
            state_d = ST_RESOLVE;
          end
`endif
        end
      end

      ST_RESOLVE: begin
        if (p1_cap_q && p2_cap_q) begin
          if (p1_mv_q == p2_mv_q) begin
            // matching moves: attacker lands the hit and keeps the turn
            turn_toggle = 1'b0;
            if (turn_q) p2_inc = 1'b1;
            else        p1_inc = 1'b1;
          end
        end else if (p1_cap_q) begin
          p1_inc = 1'b1;
        end else if (p2_cap_q) begin
          p2_inc = 1'b1;
        end

        if (p1_inc && (p1_score_q < WIN_SC)) p1_score_d = p1_score_q + 2'd1;
        if (p2_inc && (p2_score_q < WIN_SC)) p2_score_d = p2_score_q + 2'd1;
        if (turn_toggle) turn_d = !turn_q;

        if (p1_inc && (p1_score_d == WIN_SC)) begin
          winner_d = WIN_P1;
          state_d  = ST_MATCH_END;
        end else if (p2_inc && (p2_score_d == WIN_SC)) begin
          winner_d = WIN_P2;
          state_d  = ST_MATCH_END;
        end else begin
          state_d      = ST_ROUND_END;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(ROUND_HOLD);
        end
      end

      ST_ROUND_END: begin
        if (set_pulse) begin
          state_d    = ST_IDLE;
          p1_score_d = '0;
          p2_score_d = '0;
          winner_d   = WIN_NONE;
          tmr_clear  = 1'b1;
        end else if (tmr_expire) begin
          state_d  = ST_COLLECT;
          p1_cap_d = 1'b0;
          p2_cap_d = 1'b0;
`ifdef GAME_TIMEOUT_EN
          tmr_load     = 1'b1;
          tmr_load_val = turn_len(speed_q);
`else
          tmr_clear    = 1'b1;
`endif
        end
      end

      ST_MATCH_END: begin
        // result stays on display until the next match is started
        if (start_pulse) begin
          state_d   = ST_IDLE;
          tmr_clear = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        tmr_clear = 1'b1;
      end
    endcase

    round_done_d = (state_d == ST_RESOLVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      turn_q       <= 1'b0;
      p1_score_q   <= '0;
      p2_score_q   <= '0;
      round_done_q <= 1'b0;
      winner_q     <= WIN_NONE;
      pve_q        <= 1'b0;
      speed_q      <= '0;
      p1_cap_q     <= 1'b0;
      p2_cap_q     <= 1'b0;
      p1_mv_q      <= '0;
      p2_mv_q      <= '0;
    end else begin
      state_q      <= state_d;
      turn_q       <= turn_d;
      p1_score_q   <= p1_score_d;
      p2_score_q   <= p2_score_d;
      round_done_q <= round_done_d;
      winner_q     <= winner_d;
      pve_q        <= pve_d;
      speed_q      <= speed_d;
      p1_cap_q     <= p1_cap_d;
      p2_cap_q     <= p2_cap_d;
      p1_mv_q      <= p1_mv_d;
      p2_mv_q      <= p2_mv_d;
    end
  end

  assign state      = state_q;
  assign turn       = turn_q;
  assign p1_score   = p1_score_q;
  assign p2_score   = p2_score_q;
  assign round_done = round_done_q;
  assign winner     = winner_q;
  // The shared counter also runs the post-round hold; only the turn
  // deadline is meaningful to the display. Without the timeout build the
  // counter is cleared on every COLLECT entry, so this reads 0.
  assign timer      = (state_q == ST_COLLECT) ? tmr_count : '0;

endmodule

// File: tb/tb_rps_match_scheduler.sv
// Scoreboard bench for rps_match_scheduler: the stimulus process pushes the
// expected post-round outcome before each round; a monitor process pops and
// compares it in the cycle after every round_done pulse.
`timescale 1ns/1ps
module tb_rps_match_scheduler;

`ifdef GAME_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk, rst;
  logic       start_pulse, set_pulse, tick;
  logic [1:0] p1_move, p2_move, cpu_move, cfg_speed;
  logic       p1_valid, p2_valid, cfg_pve;
  logic [2:0] state;
  logic       turn;
  logic [3:0] timer;
  logic [1:0] p1_score, p2_score, winner;
  logic       round_done;

  rps_match_scheduler #(
    .TURN_TICKS(8), .TW(4), .WINS_TO_MATCH(3), .ROUND_HOLD(2)
  ) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .set_pulse(set_pulse),
    .tick(tick), .p1_move(p1_move), .p1_valid(p1_valid), .p2_move(p2_move),
    .p2_valid(p2_valid), .cpu_move(cpu_move), .cfg_pve(cfg_pve),
    .cfg_speed(cfg_speed), .state(state), .turn(turn), .timer(timer),
    .p1_score(p1_score), .p2_score(p2_score), .round_done(round_done),
    .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0] p1;
    logic [1:0] p2;
    logic       trn;
    logic [1:0] win;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input logic [1:0] p1, input logic [1:0] p2,
                              input logic trn, input logic [1:0] win,
                              input logic [2:0] st);
    exp_t e;
    e.p1 = p1; e.p2 = p2; e.trn = trn; e.win = win; e.st = st;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // monitor: compare the outcome visible the cycle after each round_done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (round_done === 1'b1) begin
        @(negedge clk);
        chk("round_done_one_cycle", 32'(round_done), 32'd0);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_round: got round_done with no expected outcome queued, state %0h", state);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_p1_score", 32'(p1_score), 32'(e.p1));
          chk("rnd_p2_score", 32'(p2_score), 32'(e.p2));
          chk("rnd_turn",     32'(turn),     32'(e.trn));
          chk("rnd_winner",   32'(winner),   32'(e.win));
          chk("rnd_state",    32'(state),    32'(e.st));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, state %0h", state);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1; step(); start_pulse = 1'b0;
  endtask

  task automatic pulse_set();
    set_pulse = 1'b1; step(); set_pulse = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step();
    end
    tick = 1'b0;
  endtask

  task automatic wait_round(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (round_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: got no round_done within 20 cycles, expected a pulse", name);
    end
    @(negedge clk);
  endtask

  task automatic play(input logic [1:0] m1, input logic [1:0] m2, input exp_t e,
                      input string name);
    exp_q.push_back(e);
    p1_valid = 1'b1; p1_move = m1;
    p2_valid = 1'b1; p2_move = m2;
    step();
    p1_valid = 1'b0; p2_valid = 1'b0;
    wait_round(name);
  endtask

  initial begin
    rst = 1'b1; start_pulse = 1'b0; set_pulse = 1'b0; tick = 1'b0;
    p1_move = '0; p2_move = '0; cpu_move = '0; p1_valid = 1'b0; p2_valid = 1'b0;
    cfg_pve = 1'b0; cfg_speed = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_state", 32'(state), 32'h1);
    chk("rst_turn", 32'(turn), 32'd0);
    chk("rst_timer", 32'(timer), 32'd0);
    chk("rst_scores", {p1_score, p2_score}, 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_round_done", 32'(round_done), 32'd0);

    // settings menu
    pulse_set();   @(negedge clk); chk("idle_to_setting", 32'(state), 32'h4);
    pulse_start(); @(negedge clk); chk("setting_ignores_start", 32'(state), 32'h4);
    pulse_set();   @(negedge clk); chk("setting_to_idle", 32'(state), 32'h1);

    // start beats set; speed 0 loads the full turn
    cfg_speed = 2'd0; start_pulse = 1'b1; set_pulse = 1'b1; step();
    start_pulse = 1'b0; set_pulse = 1'b0;
    @(negedge clk);
    chk("start_priority_state", 32'(state), 32'h2);
    chk("speed0_timer", 32'(timer), TO_EN ? 32'd8 : 32'd0);
    pulse_set(); @(negedge clk); chk("abort_collect", 32'(state), 32'h1);

    cfg_speed = 2'd2; pulse_start(); @(negedge clk);
    chk("speed2_timer", 32'(timer), TO_EN ? 32'd2 : 32'd0);
    pulse_set(); @(negedge clk); chk("abort_collect2", 32'(state), 32'h1);

    // PVP match
    cfg_speed = 2'd0; pulse_start();
    play(2'b01, 2'b01, mk(2'd1, 2'd0, 1'b0, 2'b00, 3'b110), "pvp_equal");
    tick_n(2); @(negedge clk); chk("hold_to_collect", 32'(state), 32'h2);
    play(2'b01, 2'b10, mk(2'd1, 2'd0, 1'b1, 2'b00, 3'b110), "pvp_differ");
    tick_n(2);
    play(2'b11, 2'b11, mk(2'd1, 2'd1, 1'b1, 2'b00, 3'b110), "pvp_p2_attack");
    tick_n(2);
    // p1 commits 10; a second p1 strobe with 11 must not replace it
    exp_q.push_back(mk(2'd1, 2'd1, 1'b0, 2'b00, 3'b110));
    p1_valid = 1'b1; p1_move = 2'b10; step();
    p1_move = 2'b11; step();
    p1_valid = 1'b0; p2_valid = 1'b1; p2_move = 2'b11; step();
    p2_valid = 1'b0;
    wait_round("late_strobe_ignored");
    tick_n(2);
    play(2'b11, 2'b11, mk(2'd2, 2'd1, 1'b0, 2'b00, 3'b110), "pvp_to_2_1");
    pulse_set(); @(negedge clk);
    chk("abort_hold_state", 32'(state), 32'h1);
    chk("abort_hold_scores", {p1_score, p2_score}, 32'd0);
    chk("abort_hold_winner", 32'(winner), 32'd0);

    // speed 3: one-tick deadline
    cfg_speed = 2'd3; pulse_start(); @(negedge clk);
    chk("speed3_timer", 32'(timer), TO_EN ? 32'd1 : 32'd0);
`ifdef GAME_TIMEOUT_EN
    exp_q.push_back(mk(2'd1, 2'd0, 1'b1, 2'b00, 3'b110));
    p1_valid = 1'b1; p1_move = 2'b01; step(); p1_valid = 1'b0;
    tick_n(1);
    wait_round("timeout_p1_only");
`else
    p1_valid = 1'b1; p1_move = 2'b01; step(); p1_valid = 1'b0;
    tick_n(20); @(negedge clk);
    chk("no_timeout_state", 32'(state), 32'h2);
    exp_q.push_back(mk(2'd0, 2'd0, 1'b1, 2'b00, 3'b110));
    p2_valid = 1'b1; p2_move = 2'b10; step(); p2_valid = 1'b0;
    wait_round("late_p2_resolves");
`endif
    pulse_set(); @(negedge clk); chk("abort_after_speed3", 32'(state), 32'h1);

    // PVE match; config changes after start must have no effect
    cfg_pve = 1'b1; cfg_speed = 2'd0; pulse_start();
    cfg_pve = 1'b0; cfg_speed = 2'd3;
    exp_q.push_back(mk(2'd1, 2'd0, 1'b0, 2'b00, 3'b110));
    p1_valid = 1'b1; p1_move = 2'b01; cpu_move = 2'b01; step(); p1_valid = 1'b0;
    wait_round("pve_r1");
    tick_n(2); @(negedge clk);
    chk("cfg_latched_timer", 32'(timer), TO_EN ? 32'd8 : 32'd0);
    exp_q.push_back(mk(2'd2, 2'd0, 1'b0, 2'b00, 3'b110));
    p1_valid = 1'b1; p1_move = 2'b10; cpu_move = 2'b10; step(); p1_valid = 1'b0;
    wait_round("pve_r2");
    tick_n(2);
    exp_q.push_back(mk(2'd3, 2'd0, 1'b0, 2'b01, 3'b011));
    p1_valid = 1'b1; p1_move = 2'b11; cpu_move = 2'b11; step(); p1_valid = 1'b0;
    wait_round("pve_r3");
    tick_n(3); @(negedge clk);
    chk("match_end_held", 32'(state), 32'h3);
    pulse_start(); @(negedge clk);
    chk("match_end_to_idle", 32'(state), 32'h1);
    chk("idle_keeps_score", 32'(p1_score), 32'd3);
    chk("idle_keeps_winner", 32'(winner), 32'h1);

    // asynchronous reset mid-COLLECT with p1 at 2
    cfg_pve = 1'b0; cfg_speed = 2'd0; pulse_start();
    chk("new_match_clears", {p1_score, winner}, 32'd0);
    play(2'b01, 2'b01, mk(2'd1, 2'd0, 1'b0, 2'b00, 3'b110), "pre_rst_r1");
    tick_n(2);
    play(2'b10, 2'b10, mk(2'd2, 2'd0, 1'b0, 2'b00, 3'b110), "pre_rst_r2");
    tick_n(2); @(negedge clk);
    chk("pre_rst_p1", 32'(p1_score), 32'd2);
    @(posedge clk); #1 rst = 1'b1;
    #2;
    chk("async_rst_state", 32'(state), 32'h1);
    @(negedge clk);
    chk("rst_mid_scores", {p1_score, p2_score}, 32'd0);
    chk("rst_mid_winner", 32'(winner), 32'd0);
    chk("rst_mid_timer", 32'(timer), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
